// File: rtl/sal_cmd_sched_pkg.sv
// Shared DDR scheduler types: command encoding and the per-bank field types
// carried alongside each command.
package sal_ddr_params;

    typedef logic [15:0] dram_ra_t;
    typedef logic [9:0]  dram_ca_t;
    typedef logic [3:0]  axi_id_t;
    typedef logic [7:0]  axi_len_t;
    typedef logic [7:0]  seq_num_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } sal_cmd_t;

endpackage

// File: rtl/sal_cmd_sched_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (modulo N, N a power of two) receives a one-hot grant.
module sal_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int LW = $clog2(N);

    logic [LW-1:0] idx_s;
    logic          found_s;

    // Scan from the pointer upward; index arithmetic wraps naturally at N.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = ptr + i[LW-1:0];
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/sal_cmd_sched.sv
// Inter-bank command scheduler: picks one command per cycle across bank
// controllers under class priority, round-robin fairness and shared timing.
module sal_cmd_sched
    import sal_ddr_params::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int TW        = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_BANKS-1:0]         act_req_i,
    input  logic [NUM_BANKS-1:0]         rd_req_i,
    input  logic [NUM_BANKS-1:0]         wr_req_i,
    input  logic [NUM_BANKS-1:0]         pre_req_i,
    input  logic [NUM_BANKS-1:0]         ref_req_i,
    input  dram_ra_t                     ra_i      [NUM_BANKS],
    input  dram_ca_t                     ca_i      [NUM_BANKS],
    input  axi_id_t                      id_i      [NUM_BANKS],
    input  axi_len_t                     len_i     [NUM_BANKS],
    input  seq_num_t                     seq_num_i [NUM_BANKS],
    output logic [NUM_BANKS-1:0]         act_gnt_o,
    output logic [NUM_BANKS-1:0]         rd_gnt_o,
    output logic [NUM_BANKS-1:0]         wr_gnt_o,
    output logic [NUM_BANKS-1:0]         pre_gnt_o,
    output logic [NUM_BANKS-1:0]         ref_gnt_o,
    input  logic [TW-1:0]                t_rrd_m1_i,
    input  logic [TW-1:0]                t_ccd_m1_i,
    input  logic [TW-1:0]                t_wtr_m1_i,
    input  logic [TW-1:0]                t_rtw_m1_i,
    output logic                         cmd_valid_o,
    output sal_cmd_t                     cmd_o,
    output logic [$clog2(NUM_BANKS)-1:0] cmd_bk_o,
    output dram_ra_t                     cmd_ra_o,
    output dram_ca_t                     cmd_ca_o,
    output axi_id_t                      cmd_id_o,
    output axi_len_t                     cmd_len_o,
    output seq_num_t                     cmd_seq_num_o
);

    localparam int BW = $clog2(NUM_BANKS);

    logic [TW-1:0] rrd_r, ccd_r, wtr_r, rtw_r;
    logic [BW-1:0] ref_ptr_r, cas_ptr_r, act_ptr_r, pre_ptr_r;

    logic                 rd_ok_s, wr_ok_s, act_ok_s;
    logic [NUM_BANKS-1:0] rd_elig_s, wr_elig_s, cas_elig_s, act_elig_s;
    logic [NUM_BANKS-1:0] ref_arb_s, cas_arb_s, act_arb_s, pre_arb_s;
    logic [NUM_BANKS-1:0] all_gnt_s;
    logic [BW-1:0]        gnt_idx_s;
    logic [BW-1:0]        gnt_idx_inc_s;
    sal_cmd_t             cmd_nxt_s;

    assign act_ok_s   = (rrd_r == '0);
    assign rd_ok_s    = (ccd_r == '0) && (wtr_r == '0);
    assign wr_ok_s    = (ccd_r == '0) && (rtw_r == '0);
    assign rd_elig_s  = rd_req_i & {NUM_BANKS{rd_ok_s}};
    assign wr_elig_s  = wr_req_i & {NUM_BANKS{wr_ok_s}};
    assign cas_elig_s = rd_elig_s | wr_elig_s;
    assign act_elig_s = act_req_i & {NUM_BANKS{act_ok_s}};

    sal_rr_arb #(.N(NUM_BANKS)) u_ref_arb (.req(ref_req_i),  .ptr(ref_ptr_r), .gnt(ref_arb_s));
    sal_rr_arb #(.N(NUM_BANKS)) u_cas_arb (.req(cas_elig_s), .ptr(cas_ptr_r), .gnt(cas_arb_s));
    sal_rr_arb #(.N(NUM_BANKS)) u_act_arb (.req(act_elig_s), .ptr(act_ptr_r), .gnt(act_arb_s));
    sal_rr_arb #(.N(NUM_BANKS)) u_pre_arb (.req(pre_req_i),  .ptr(pre_ptr_r), .gnt(pre_arb_s));

    // Class priority REF > CAS > ACT > PRE; within CAS a bank eligible for both prefers RD.
    always_comb begin
        ref_gnt_o = '0;
        rd_gnt_o  = '0;
        wr_gnt_o  = '0;
        act_gnt_o = '0;
        pre_gnt_o = '0;
        if (!rst_n) begin
            ref_gnt_o = '0;
        end else if (|ref_req_i) begin
            ref_gnt_o = ref_arb_s;
        end else if (|cas_elig_s) begin
            rd_gnt_o = cas_arb_s & rd_elig_s;
            wr_gnt_o = cas_arb_s & wr_elig_s & ~rd_elig_s;
        end else if (|act_elig_s) begin
            act_gnt_o = act_arb_s;
        end else begin
            pre_gnt_o = pre_arb_s;
        end
    end

    assign all_gnt_s     = ref_gnt_o | rd_gnt_o | wr_gnt_o | act_gnt_o | pre_gnt_o;
    assign gnt_idx_inc_s = gnt_idx_s + BW'(1'b1);

    // One-hot grant to bank index and command type.
    always_comb begin
        gnt_idx_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (all_gnt_s[b]) begin
                gnt_idx_s = b[BW-1:0];
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
        if (|ref_gnt_o)      cmd_nxt_s = CMD_REF;
        else if (|rd_gnt_o)  cmd_nxt_s = CMD_RD;
        else if (|wr_gnt_o)  cmd_nxt_s = CMD_WR;
        else if (|act_gnt_o) cmd_nxt_s = CMD_ACT;
        else if (|pre_gnt_o) cmd_nxt_s = CMD_PRE;
        else                 cmd_nxt_s = CMD_NOP;
    end

    // Shared timing counters: load on grant, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_r <= '0;
            ccd_r <= '0;
            wtr_r <= '0;
            rtw_r <= '0;
        end else begin
            rrd_r <= (|act_gnt_o) ? t_rrd_m1_i : ((rrd_r == '0) ? '0 : rrd_r - TW'(1'b1));
            ccd_r <= (|(rd_gnt_o | wr_gnt_o)) ? t_ccd_m1_i : ((ccd_r == '0) ? '0 : ccd_r - TW'(1'b1));
            wtr_r <= (|wr_gnt_o) ? t_wtr_m1_i : ((wtr_r == '0) ? '0 : wtr_r - TW'(1'b1));
            rtw_r <= (|rd_gnt_o) ? t_rtw_m1_i : ((rtw_r == '0) ? '0 : rtw_r - TW'(1'b1));
        end
    end

    // Round-robin pointers advance past the bank just granted in that class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_ptr_r <= '0;
            cas_ptr_r <= '0;
            act_ptr_r <= '0;
            pre_ptr_r <= '0;
        end else begin
            ref_ptr_r <= (|ref_gnt_o) ? gnt_idx_inc_s : ref_ptr_r;
            cas_ptr_r <= (|(rd_gnt_o | wr_gnt_o)) ? gnt_idx_inc_s : cas_ptr_r;
            act_ptr_r <= (|act_gnt_o) ? gnt_idx_inc_s : act_ptr_r;
            pre_ptr_r <= (|pre_gnt_o) ? gnt_idx_inc_s : pre_ptr_r;
        end
    end

    // Issued command register; fields not carried by a command type hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_o   <= 1'b0;
            cmd_o         <= CMD_NOP;
            cmd_bk_o      <= '0;
            cmd_ra_o      <= '0;
            cmd_ca_o      <= '0;
            cmd_id_o      <= '0;
            cmd_len_o     <= '0;
            cmd_seq_num_o <= '0;
        end else begin
            cmd_valid_o <= |all_gnt_s;
            cmd_o       <= cmd_nxt_s;
            cmd_bk_o    <= (|all_gnt_s) ? gnt_idx_s : cmd_bk_o;
            cmd_ra_o    <= (|act_gnt_o) ? ra_i[gnt_idx_s] : cmd_ra_o;
            if (|(rd_gnt_o | wr_gnt_o)) begin
                cmd_ca_o  <= ca_i[gnt_idx_s];
                cmd_id_o  <= id_i[gnt_idx_s];
                cmd_len_o <= len_i[gnt_idx_s];
            end else begin
                cmd_ca_o  <= cmd_ca_o;
                cmd_id_o  <= cmd_id_o;
                cmd_len_o <= cmd_len_o;
            end
            cmd_seq_num_o <= (|(act_gnt_o | rd_gnt_o | wr_gnt_o)) ? seq_num_i[gnt_idx_s] : cmd_seq_num_o;
        end
    end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Directed bench for sal_cmd_sched: priority, round-robin, timing counters,
// command register and reset behaviour with hand-computed expectations.
module tb_sal_cmd_sched;
    import sal_ddr_params::*;

    localparam int NB = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
    dram_ra_t      ra  [NB];
    dram_ca_t      ca  [NB];
    axi_id_t       id  [NB];
    axi_len_t      len [NB];
    seq_num_t      seq [NB];
    logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [TW-1:0] t_rrd, t_ccd, t_wtr, t_rtw;
    logic          cmd_valid;
    sal_cmd_t      cmd;
    logic [1:0]    cmd_bk;
    dram_ra_t      cmd_ra;
    dram_ca_t      cmd_ca;
    axi_id_t       cmd_id;
    axi_len_t      cmd_len;
    seq_num_t      cmd_seq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sal_cmd_sched #(.NUM_BANKS(NB), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
        .pre_req_i(pre_req), .ref_req_i(ref_req),
        .ra_i(ra), .ca_i(ca), .id_i(id), .len_i(len), .seq_num_i(seq),
        .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
        .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
        .t_rrd_m1_i(t_rrd), .t_ccd_m1_i(t_ccd), .t_wtr_m1_i(t_wtr), .t_rtw_m1_i(t_rtw),
        .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_bk_o(cmd_bk),
        .cmd_ra_o(cmd_ra), .cmd_ca_o(cmd_ca), .cmd_id_o(cmd_id),
        .cmd_len_o(cmd_len), .cmd_seq_num_o(cmd_seq)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_reqs();
        act_req = 4'b0000; rd_req = 4'b0000; wr_req = 4'b0000;
        pre_req = 4'b0000; ref_req = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        t_rrd = 4'd0; t_ccd = 4'd0; t_wtr = 4'd0; t_rtw = 4'd0;
        for (int b = 0; b < NB; b++) begin
            ra[b]  = dram_ra_t'(16'hA000 + b);
            ca[b]  = dram_ca_t'(10'h100 + b);
            id[b]  = axi_id_t'(b + 1);
            len[b] = axi_len_t'(8'h10 + b);
            seq[b] = seq_num_t'(8'h50 + b);
        end

        // Reset state; requests during reset must not be granted
        act_req = 4'b1111; ref_req = 4'b0001;
        #2;
        check_eq("rst_act_gnt", act_gnt, 4'b0000);
        check_eq("rst_ref_gnt", ref_gnt, 4'b0000);
        check_eq("rst_valid", cmd_valid, 1'b0);
        check_eq("rst_cmd", cmd, CMD_NOP);
        check_eq("rst_bk", cmd_bk, 2'd0);
        check_eq("rst_seq", cmd_seq, 8'h00);
        idle(2);
        rst_n = 1'b1;
        clear_reqs();
        step();

        // ACT banks 0 and 1, t_rrd_m1=3: grants at cycle 0 and 4
        t_rrd = 4'd3;
        act_req = 4'b0011;
        #1;
        check_eq("act_c0_gnt", act_gnt, 4'b0001);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) begin
                check_eq("act_c1_valid", cmd_valid, 1'b1);
                check_eq("act_c1_cmd", cmd, CMD_ACT);
                check_eq("act_c1_bk", cmd_bk, 2'd0);
                check_eq("act_c1_ra", cmd_ra, 16'hA000);
                act_req = 4'b0010;
            end else if (c == 2) begin
                check_eq("act_c2_valid", cmd_valid, 1'b0);
                check_eq("act_c2_cmd", cmd, CMD_NOP);
                check_eq("act_c2_ra_hold", cmd_ra, 16'hA000);
            end
            #1;
            check_eq("act_wait_gnt", act_gnt, (c == 4) ? 4'b0010 : 4'b0000);
        end
        step();
        act_req = 4'b0000;
        check_eq("act_c5_cmd", cmd, CMD_ACT);
        check_eq("act_c5_bk", cmd_bk, 2'd1);
        check_eq("act_c5_ra", cmd_ra, 16'hA001);
        check_eq("act_c5_seq", cmd_seq, 8'h51);
        idle(4);

        // REF beats RD in the same cycle; RD follows
        ref_req = 4'b0100; rd_req = 4'b0001;
        #1;
        check_eq("ref_pri_ref", ref_gnt, 4'b0100);
        check_eq("ref_pri_rd", rd_gnt, 4'b0000);
        step();
        ref_req = 4'b0000;
        #1;
        check_eq("ref_cmd", cmd, CMD_REF);
        check_eq("ref_bk", cmd_bk, 2'd2);
        check_eq("rd_after_ref", rd_gnt, 4'b0001);
        step();
        rd_req = 4'b0000;
        check_eq("rd0_cmd", cmd, CMD_RD);
        check_eq("rd0_bk", cmd_bk, 2'd0);
        check_eq("rd0_ca", cmd_ca, 10'h100);
        check_eq("rd0_id", cmd_id, 4'd1);

        // Same bank asks RD and WR: RD wins
        rd_req = 4'b0100; wr_req = 4'b0100;
        #1;
        check_eq("rdwr_rd", rd_gnt, 4'b0100);
        check_eq("rdwr_wr", wr_gnt, 4'b0000);
        step();
        clear_reqs();
        check_eq("rdwr_cmd", cmd, CMD_RD);

        // WR bank1 then RD bank3 held: t_wtr_m1=5 delays RD by 6 cycles
        t_ccd = 4'd1; t_wtr = 4'd5;
        wr_req = 4'b0010;
        #1;
        check_eq("wr_gnt", wr_gnt, 4'b0010);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) begin
                wr_req = 4'b0000;
                rd_req = 4'b1000;
                check_eq("wr_cmd", cmd, CMD_WR);
                check_eq("wr_bk", cmd_bk, 2'd1);
                check_eq("wr_len", cmd_len, 8'h11);
            end
            #1;
            check_eq("wtr_rd_gnt", rd_gnt, (c == 6) ? 4'b1000 : 4'b0000);
        end
        step();
        rd_req = 4'b0000;
        check_eq("wtr_rd_cmd", cmd, CMD_RD);
        check_eq("wtr_rd_bk", cmd_bk, 2'd3);

        // RD on all banks, t_ccd_m1=0: 0,1,2,3,0 back to back
        t_ccd = 4'd0;
        idle(2);
        rd_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("rr_rd_gnt", rd_gnt, 32'(1) << (k % 4));
            step();
        end
        rd_req = 4'b0000;
        check_eq("rr_last_bk", cmd_bk, 2'd0);

        // ACT bank0 + PRE bank1 held, t_rrd_m1=2: ACT 0, PRE 1, PRE 2, ACT 3
        t_rrd = 4'd2;
        act_req = 4'b0001; pre_req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq("ap_act", act_gnt, (c == 0 || c == 3) ? 4'b0001 : 4'b0000);
            check_eq("ap_pre", pre_gnt, (c == 1 || c == 2) ? 4'b0010 : 4'b0000);
            step();
        end
        clear_reqs();
        check_eq("ap_cmd", cmd, CMD_ACT);

        // Reset with rrd loaded: outputs clear at once, ACT granted right after release
        t_rrd = 4'd3;
        idle(3);
        act_req = 4'b0001;
        #1;
        check_eq("mr_act_gnt", act_gnt, 4'b0001);
        step();
        check_eq("mr_valid_pre", cmd_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mr_valid", cmd_valid, 1'b0);
        check_eq("mr_cmd", cmd, CMD_NOP);
        check_eq("mr_ra", cmd_ra, 16'h0000);
        check_eq("mr_gnt_in_rst", act_gnt, 4'b0000);
        step();
        rst_n = 1'b1;
        #1;
        check_eq("mr_act_after", act_gnt, 4'b0001);
        step();
        act_req = 4'b0000;
        check_eq("mr_cmd_after", cmd, CMD_ACT);
        check_eq("mr_valid_after", cmd_valid, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
